// File: rtl/rat_shot_ctrl.sv
// rat_shot_ctrl: slot allocator and rollback sequencer for the RAT snapshot store.
// Slots are a circular queue (head = oldest, tail = next to hand out). Up to
// four rename lanes are granted per cycle in lane order. Retire frees the
// oldest slot. Rollback frees a slot and everything younger, then drives a
// read / restore handshake toward the storage array and the RAT.
module rat_shot_ctrl #(
   parameter int SLOTS = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alloc_req_a,
   input  logic                       alloc_req_b,
   input  logic                       alloc_req_c,
   input  logic                       alloc_req_d,
   output logic                       alloc_gnt_a,
   output logic                       alloc_gnt_b,
   output logic                       alloc_gnt_c,
   output logic                       alloc_gnt_d,
   output logic [$clog2(SLOTS)-1:0]   alloc_id_a,
   output logic [$clog2(SLOTS)-1:0]   alloc_id_b,
   output logic [$clog2(SLOTS)-1:0]   alloc_id_c,
   output logic [$clog2(SLOTS)-1:0]   alloc_id_d,
   input  logic [1:0]                 rob_kill,
   input  logic [7:0]                 rob_kill_name,
   output logic                       shot_rd_en,
   output logic [$clog2(SLOTS)-1:0]   shot_rd_idx,
   output logic                       rob_kill_start,
   output logic [SLOTS-1:0]           slot_valid,
   output logic [$clog2(SLOTS):0]     free_cnt,
   output logic                       ctrl_err
);

   localparam int IDW = $clog2(SLOTS);
   localparam logic [IDW:0] SLOTS_C = (IDW+1)'(SLOTS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD      = 2'd1,
      ST_RESTORE = 2'd2
   } state_t;

   state_t           state_r;
   logic [IDW-1:0]   head_r;
   logic [IDW-1:0]   tail_r;
   logic [IDW:0]     count_r;

   logic [3:0]       req_s;
   logic [3:0]       gnt_s;
   logic [IDW-1:0]   id_s [4];
   logic [2:0]       gnt_cnt_s;
   logic             stop_s;
   logic [IDW:0]     used_s;
   logic             blocked_s;

   logic             retire_req_s;
   logic             rb_req_s;
   logic             bad_kill_s;
   logic [IDW-1:0]   kill_id_s;
   logic             kill_hit_s;
   logic             retire_ok_s;
   logic             rb_ok_s;
   logic             err_s;

   logic [IDW-1:0]   head_n_s;
   logic [IDW-1:0]   tail_n_s;
   logic [IDW:0]     count_n_s;
   logic [IDW-1:0]   rb_cnt_s;
   logic [IDW-1:0]   off_s;
   logic [SLOTS-1:0] valid_n_s;

   // Upper name bits carry no slot information.
   logic             unused_name_s;
   assign unused_name_s = ^rob_kill_name[7:IDW];

   assign req_s       = {alloc_req_d, alloc_req_c, alloc_req_b, alloc_req_a};
   assign alloc_gnt_a = gnt_s[0];
   assign alloc_gnt_b = gnt_s[1];
   assign alloc_gnt_c = gnt_s[2];
   assign alloc_gnt_d = gnt_s[3];
   assign alloc_id_a  = id_s[0];
   assign alloc_id_b  = id_s[1];
   assign alloc_id_c  = id_s[2];
   assign alloc_id_d  = id_s[3];

   // Decode the ROB command and judge whether it is legal against current state.
   always_comb begin
      retire_req_s = 1'b0;
      rb_req_s     = 1'b0;
      bad_kill_s   = 1'b0;
      case (rob_kill)
         2'b01:   retire_req_s = 1'b1;
         2'b10:   rb_req_s     = 1'b1;
         2'b11:   bad_kill_s   = 1'b1;
         default: bad_kill_s   = 1'b0;
      endcase
      kill_id_s   = rob_kill_name[IDW-1:0];
      kill_hit_s  = slot_valid[kill_id_s];
      retire_ok_s = retire_req_s & (kill_id_s == head_r) & kill_hit_s;
      rb_ok_s     = rb_req_s & (state_r == ST_IDLE) & kill_hit_s;
      err_s       = (retire_req_s & ~retire_ok_s) | (rb_req_s & ~rb_ok_s) | bad_kill_s;
   end

   // Prefix grant walk: lanes in order, stop at the first refused requester.
   always_comb begin
      blocked_s = ~reset | (state_r != ST_IDLE) | rb_req_s;
      gnt_s     = 4'b0000;
      gnt_cnt_s = 3'd0;
      stop_s    = 1'b0;
      used_s    = count_r;
      for (int i = 0; i < 4; i++) begin
         id_s[i] = tail_r + IDW'(gnt_cnt_s);
         used_s  = count_r + (IDW+1)'(gnt_cnt_s);
         if (blocked_s) begin
            gnt_s[i] = 1'b0;
         end else if (req_s[i] && !stop_s) begin
            if (used_s < SLOTS_C) begin
               gnt_s[i]  = 1'b1;
               gnt_cnt_s = gnt_cnt_s + 3'd1;
            end else begin
               stop_s = 1'b1;
            end
         end else begin
            gnt_s[i] = 1'b0;
         end
      end
   end

   // Next pointers, occupancy and valid bitmap from retire, rollback and grants.
   always_comb begin
      rb_cnt_s = kill_id_s - head_r;
      if (retire_ok_s) begin
         head_n_s = head_r + IDW'(1);
      end else begin
         head_n_s = head_r;
      end
      if (rb_ok_s) begin
         tail_n_s  = kill_id_s;
         count_n_s = {1'b0, rb_cnt_s};
      end else begin
         tail_n_s  = tail_r + IDW'(gnt_cnt_s);
         count_n_s = count_r + (IDW+1)'(gnt_cnt_s) - (IDW+1)'(retire_ok_s);
      end
      off_s = '0;
      for (int i = 0; i < SLOTS; i++) begin
         off_s        = IDW'(i) - head_n_s;
         valid_n_s[i] = ({1'b0, off_s} < count_n_s);
      end
   end

   // Queue state, sticky error and the rollback read/restore sequencer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         head_r         <= '0;
         tail_r         <= '0;
         count_r        <= '0;
         slot_valid     <= '0;
         free_cnt       <= SLOTS_C;
         shot_rd_en     <= 1'b0;
         shot_rd_idx    <= '0;
         rob_kill_start <= 1'b0;
         ctrl_err       <= 1'b0;
      end else begin
         head_r     <= head_n_s;
         tail_r     <= tail_n_s;
         count_r    <= count_n_s;
         slot_valid <= valid_n_s;
         free_cnt   <= SLOTS_C - count_n_s;
         ctrl_err   <= ctrl_err | err_s;
         case (state_r)
            ST_IDLE: begin
               rob_kill_start <= 1'b0;
               if (rb_ok_s) begin
                  state_r     <= ST_RD;
                  shot_rd_en  <= 1'b1;
                  shot_rd_idx <= kill_id_s;
               end else begin
                  state_r     <= ST_IDLE;
                  shot_rd_en  <= 1'b0;
               end
            end
            ST_RD: begin
               state_r        <= ST_RESTORE;
               shot_rd_en     <= 1'b0;
               rob_kill_start <= 1'b1;
            end
            ST_RESTORE: begin
               state_r        <= ST_IDLE;
               shot_rd_en     <= 1'b0;
               rob_kill_start <= 1'b0;
            end
            default: begin
               state_r        <= ST_IDLE;
               shot_rd_en     <= 1'b0;
               rob_kill_start <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rat_shot_ctrl.sv
// tb_rat_shot_ctrl: directed and random stimulus against a queue-based model
// of the snapshot slot allocator.
module tb_rat_shot_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       alloc_req_a, alloc_req_b, alloc_req_c, alloc_req_d;
   logic       alloc_gnt_a, alloc_gnt_b, alloc_gnt_c, alloc_gnt_d;
   logic [2:0] alloc_id_a, alloc_id_b, alloc_id_c, alloc_id_d;
   logic [1:0] rob_kill;
   logic [7:0] rob_kill_name;
   logic       shot_rd_en;
   logic [2:0] shot_rd_idx;
   logic       rob_kill_start;
   logic [7:0] slot_valid;
   logic [3:0] free_cnt;
   logic       ctrl_err;

   int n_chk  = 0;
   int n_pass = 0;

   // model: allocated slots oldest first, next slot to hand out, rollback phase
   int   q[$];
   int   m_tail;
   int   m_phase;
   int   m_rd_idx;
   bit   m_err;
   logic [3:0] e_gnt;
   int   e_id [4];

   rat_shot_ctrl #(.SLOTS(8)) dut (
      .clk(clk), .reset(reset),
      .alloc_req_a(alloc_req_a), .alloc_req_b(alloc_req_b),
      .alloc_req_c(alloc_req_c), .alloc_req_d(alloc_req_d),
      .alloc_gnt_a(alloc_gnt_a), .alloc_gnt_b(alloc_gnt_b),
      .alloc_gnt_c(alloc_gnt_c), .alloc_gnt_d(alloc_gnt_d),
      .alloc_id_a(alloc_id_a), .alloc_id_b(alloc_id_b),
      .alloc_id_c(alloc_id_c), .alloc_id_d(alloc_id_d),
      .rob_kill(rob_kill), .rob_kill_name(rob_kill_name),
      .shot_rd_en(shot_rd_en), .shot_rd_idx(shot_rd_idx),
      .rob_kill_start(rob_kill_start), .slot_valid(slot_valid),
      .free_cnt(free_cnt), .ctrl_err(ctrl_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic void model_reset();
      q.delete();
      m_tail   = 0;
      m_phase  = 0;
      m_rd_idx = 0;
      m_err    = 1'b0;
   endfunction

   function automatic int model_map();
      int m = 0;
      foreach (q[i]) m = m | (1 << q[i]);
      return m;
   endfunction

   // expected grants for the current inputs
   function automatic void model_grant(input logic rst, input logic [3:0] req, input logic [1:0] kill);
      int  k = 0;
      bit  stop = 1'b0;
      e_gnt = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         e_id[i] = 0;
         if (rst && m_phase == 0 && kill != 2'b10 && req[i] && !stop) begin
            if (q.size() + k < 8) begin
               e_gnt[i] = 1'b1;
               e_id[i]  = (m_tail + k) % 8;
               k++;
            end else begin
               stop = 1'b1;
            end
         end
      end
   endfunction

   function automatic void model_update(input logic rst, input logic [1:0] kill, input logic [7:0] name);
      int p;
      int id;
      int j;
      bit acc;
      if (!rst) begin
         model_reset();
         return;
      end
      p   = m_phase;
      id  = int'(name[2:0]);
      acc = 1'b0;
      case (kill)
         2'b01: begin
            if (q.size() > 0 && q[0] == id) void'(q.pop_front());
            else m_err = 1'b1;
         end
         2'b10: begin
            j = -1;
            for (int i = 0; i < q.size(); i++) if (q[i] == id) j = i;
            if (p == 0 && j >= 0) begin
               while (q.size() > j) void'(q.pop_back());
               m_tail   = id;
               m_rd_idx = id;
               acc      = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         2'b11: m_err = 1'b1;
         default: ;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (e_gnt[i]) begin
            q.push_back(e_id[i]);
            m_tail = (e_id[i] + 1) % 8;
         end
      end
      if (acc) m_phase = 1;
      else if (p == 1) m_phase = 2;
      else m_phase = 0;
   endfunction

   // one clock: drive, check mid-cycle, advance model at the edge
   task automatic step(input logic rst, input logic [3:0] req, input logic [1:0] kill, input logic [7:0] name);
      int obs_id [4];
      reset         = rst;
      alloc_req_a   = req[0];
      alloc_req_b   = req[1];
      alloc_req_c   = req[2];
      alloc_req_d   = req[3];
      rob_kill      = kill;
      rob_kill_name = name;
      @(negedge clk);
      model_grant(rst, req, kill);
      obs_id[0] = int'(alloc_id_a);
      obs_id[1] = int'(alloc_id_b);
      obs_id[2] = int'(alloc_id_c);
      obs_id[3] = int'(alloc_id_d);
      check("gnt", int'({alloc_gnt_d, alloc_gnt_c, alloc_gnt_b, alloc_gnt_a}), int'(e_gnt));
      for (int i = 0; i < 4; i++)
         if (e_gnt[i]) check($sformatf("id_lane%0d", i), obs_id[i], e_id[i]);
      check("slot_valid", int'(slot_valid), model_map());
      check("free_cnt", int'(free_cnt), 8 - q.size());
      check("shot_rd_en", int'(shot_rd_en), int'(m_phase == 1));
      if (m_phase == 1) check("shot_rd_idx", int'(shot_rd_idx), m_rd_idx);
      check("rob_kill_start", int'(rob_kill_start), int'(m_phase == 2));
      check("ctrl_err", int'(ctrl_err), int'(m_err));
      @(posedge clk);
      model_update(rst, kill, name);
      #1;
   endtask

   initial begin
      logic [3:0] r_req;
      logic [1:0] r_kill;
      logic [7:0] r_name;
      logic       r_rst;
      int         sel;
      int         rnd;

      reset = 1'b0;
      {alloc_req_a, alloc_req_b, alloc_req_c, alloc_req_d} = 4'b0000;
      rob_kill      = 2'b00;
      rob_kill_name = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("rst_valid", int'(slot_valid), 0);
      check("rst_free", int'(free_cnt), 8);
      check("rst_rd_en", int'(shot_rd_en), 0);
      check("rst_rd_idx", int'(shot_rd_idx), 0);
      check("rst_kstart", int'(rob_kill_start), 0);
      check("rst_err", int'(ctrl_err), 0);

      // grants held off under reset, then four-lane allocation
      step(1'b0, 4'b1111, 2'b00, 8'd0);
      step(1'b1, 4'b1111, 2'b00, 8'd0);
      check("four_free", int'(free_cnt), 4);
      // prefix refusal into full
      step(1'b1, 4'b0011, 2'b00, 8'd0);
      step(1'b1, 4'b1101, 2'b00, 8'd0);
      check("full_free", int'(free_cnt), 0);
      // retire at full: slot freed only next cycle, then reused with wrap
      step(1'b1, 4'b1111, 2'b01, 8'd0);
      step(1'b1, 4'b0001, 2'b00, 8'd0);
      // rollback of slot 3 with head at 1
      step(1'b1, 4'b1111, 2'b10, 8'd3);
      check("rb_valid", int'(slot_valid), 8'b0000_0110);
      check("rb_rd_idx", int'(shot_rd_idx), 3);
      step(1'b1, 4'b1111, 2'b10, 8'd1);
      check("rb_err_in_rd", int'(ctrl_err), 1);
      step(1'b1, 4'b1111, 2'b00, 8'd0);
      step(1'b1, 4'b1111, 2'b00, 8'd0);
      // retire of a non-head ID with junk upper name bits
      step(1'b0, 4'b0000, 2'b00, 8'd0);
      step(1'b1, 4'b0111, 2'b00, 8'd0);
      step(1'b1, 4'b0000, 2'b01, 8'hF9);
      check("err_nonhead", int'(ctrl_err), 1);
      // rob_kill == 11 on a fresh state
      step(1'b0, 4'b0000, 2'b00, 8'd0);
      step(1'b1, 4'b0011, 2'b11, 8'd0);
      step(1'b1, 4'b0000, 2'b00, 8'd0);
      // reset asserted while in RD
      step(1'b0, 4'b0000, 2'b00, 8'd0);
      step(1'b1, 4'b0111, 2'b00, 8'd0);
      step(1'b1, 4'b0000, 2'b10, 8'd1);
      step(1'b0, 4'b1111, 2'b00, 8'd0);
      check("rd_reset_kstart", int'(rob_kill_start), 0);
      step(1'b1, 4'b0001, 2'b00, 8'd0);
      step(1'b1, 4'b0000, 2'b00, 8'd0);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         rnd    = int'($urandom);
         r_rst  = ($urandom_range(0, 59) != 0);
         r_req  = rnd[3:0];
         r_name = rnd[15:8];
         sel    = int'($urandom_range(0, 9));
         if (sel <= 3) begin
            r_kill = 2'b00;
         end else if (sel <= 6) begin
            r_kill = 2'b01;
            r_name[2:0] = (q.size() > 0) ? 3'(q[0]) : 3'(m_tail);
         end else if (sel == 7) begin
            r_kill = 2'b01;
         end else if (sel == 8) begin
            r_kill = 2'b10;
            if (q.size() > 0) r_name[2:0] = 3'(q[$urandom_range(0, q.size() - 1)]);
         end else begin
            r_kill = rnd[17:16];
         end
         step(r_rst, r_req, r_kill, r_name);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
